// File: rtl/nv_ram_rws_32x512_fifo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// nv_ram_rws_32x512_fifo_ctrl_pkg
//
// Purpose: shared sizing constants for the 32 x 512 two-port RAM FIFO
// controller and its pointer/occupancy sub-block.
//
// Contents:
//   FifoDepth  - number of RAM entries (power of two, matches the RAM macro)
//   FifoAw     - RAM address width, log2(FifoDepth)
//   FifoWidth  - payload width, matches the RAM data width
//   FifoCw     - occupancy counter width; one extra bit so that a completely
//                full FIFO (count == FifoDepth) is representable
// ---------------------------------------------------------------------------
package nv_ram_rws_32x512_fifo_ctrl_pkg;

  localparam int FifoDepth = 32;
  localparam int FifoAw    = 5;
  localparam int FifoWidth = 512;
  localparam int FifoCw    = FifoAw + 1;

endpackage : nv_ram_rws_32x512_fifo_ctrl_pkg

// File: rtl/nv_ram_rws_32x512_fifo_ctrl_ptr_cnt.sv
// ---------------------------------------------------------------------------
// nv_fifo_ptr_cnt
//
// Purpose: holds the bookkeeping state of the FIFO controller: the RAM write
// pointer, the RAM read (fetch) pointer and the occupancy count. The parent
// decides when a push, fetch or pop happens; this block only applies them.
//
// Ports:
//   clk_i    - core clock
//   rst_i    - synchronous, active-high reset
//   push_i   - an entry is written into the RAM this cycle
//   fetch_i  - an entry is read out of the RAM this cycle
//   pop_i    - the entry presented on the pop interface leaves this cycle
//   wrPtr_o  - next RAM write address
//   rdPtr_o  - next RAM read address
//   count_o  - occupancy, 0..2**AW, including the entry being presented
// ---------------------------------------------------------------------------
module nv_fifo_ptr_cnt
  import nv_ram_rws_32x512_fifo_ctrl_pkg::*;
#(
  parameter int AW = FifoAw
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          fetch_i,
  input  logic          pop_i,
  output logic [AW-1:0] wrPtr_o,
  output logic [AW-1:0] rdPtr_o,
  output logic [AW:0]   count_o
);

  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] wrPtr_d;
  logic [AW-1:0] rdPtr_q;
  logic [AW-1:0] rdPtr_d;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;

  // Next-state computation. Pointers are exactly AW bits wide so they wrap
  // from the last entry back to zero through plain binary overflow. The count
  // is one bit wider so "completely full" is distinct from "empty"; a push
  // and a pop in the same cycle cancel and leave it unchanged.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    if (push_i) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (fetch_i) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
  end

  // State registers. Reset empties the FIFO; whatever still sits in the RAM
  // is simply forgotten because both pointers return to zero together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  assign wrPtr_o = wrPtr_q;
  assign rdPtr_o = rdPtr_q;
  assign count_o = count_q;

endmodule : nv_fifo_ptr_cnt

// File: rtl/nv_ram_rws_32x512_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// nv_ram_rws_32x512_fifo_ctrl
//
// Purpose: valid/ready FIFO controller for an external two-port RAM with a
// registered read address and combinational read data. Pushes become RAM
// writes; RAM reads are issued ahead of time so the head entry is always
// sitting on rd_pd one cycle after it was fetched.
//
// Ports:
//   clk, rst          - core clock, synchronous active-high reset
//   wr_pvld/wr_prdy   - push handshake, wr_pd is the push payload
//   rd_pvld/rd_prdy   - pop handshake, rd_pd is the pop payload (= ram_dout)
//   ram_wa/we/di      - RAM write port (ram_di = wr_pd)
//   ram_ra/re         - RAM read address and read enable (address latch)
//   ram_dout          - RAM read data for the latched read address
//   count             - occupancy, including the entry presented on rd_*
//   idle              - FIFO is empty
// ---------------------------------------------------------------------------
module nv_ram_rws_32x512_fifo_ctrl
  import nv_ram_rws_32x512_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = FifoDepth,
  parameter int AW    = FifoAw,
  parameter int WIDTH = FifoWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [AW-1:0]    ram_wa,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_di,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_re,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [AW:0]      count,
  output logic             idle
);

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic          push;
  logic          pop;
  logic          fetch;
  logic [AW:0]   countNow;
  logic [AW:0]   unfetched;
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          rdPvld_q;
  logic          rdPvld_d;

  // Handshake decode. Push readiness looks only at the registered count, so
  // a pop while full does not open the door in the same cycle; the freed slot
  // becomes visible one cycle later. This keeps wr_prdy free of any path
  // from rd_prdy.
  always_comb begin
    wr_prdy = (countNow != FullCount);
    push    = wr_pvld & wr_prdy;
    pop     = rdPvld_q & rd_prdy;
  end

  // Read-ahead decision. Entries counted but not yet moved to the output
  // stage are "unfetched". A fetch happens whenever there is something to
  // read (including the entry being pushed right now, which gives the
  // empty-FIFO bypass with ram_ra == ram_wa) and the output stage is empty
  // or emptying this cycle. While the output is stalled no read is issued,
  // so the latched address and hence rd_pd stay put.
  always_comb begin
    unfetched = countNow - {{AW{1'b0}}, rdPvld_q};
    fetch     = ((unfetched != '0) | push) & (~rdPvld_q | rd_prdy);
    rdPvld_d  = rdPvld_q;
    if (fetch) begin
      rdPvld_d = 1'b1;
    end else if (pop) begin
      rdPvld_d = 1'b0;
    end
  end

  // Output-stage valid flag. It marks that the RAM read data currently on
  // ram_dout belongs to a live entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPvld_q <= 1'b0;
    end else begin
      rdPvld_q <= rdPvld_d;
    end
  end

  nv_fifo_ptr_cnt #(
    .AW (AW)
  ) u_ptr_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .fetch_i (fetch),
    .pop_i   (pop),
    .wrPtr_o (wrPtr),
    .rdPtr_o (rdPtr),
    .count_o (countNow)
  );

  // RAM-side wiring. Enables are forced low during reset so a reset in the
  // middle of traffic never disturbs the RAM contents or its read latch.
  always_comb begin
    ram_we = push & ~rst;
    ram_wa = wrPtr;
    ram_di = wr_pd;
    ram_re = fetch & ~rst;
    ram_ra = rdPtr;
  end

  assign rd_pvld = rdPvld_q;
  assign rd_pd   = ram_dout;
  assign count   = countNow;
  assign idle    = (countNow == '0);

endmodule : nv_ram_rws_32x512_fifo_ctrl

// File: tb/tb_nv_ram_rws_32x512_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nv_ram_rws_32x512_fifo_ctrl
//
// Purpose: self-checking bench for the RAM FIFO controller. It carries a
// behavioural model of the RAM macro and a queue-based model of the FIFO.
// ---------------------------------------------------------------------------
module tb_nv_ram_rws_32x512_fifo_ctrl;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int WIDTH = 512;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_pvld = 1'b0;
  logic             wr_prdy;
  logic [WIDTH-1:0] wr_pd = '0;
  logic             rd_pvld;
  logic             rd_prdy = 1'b0;
  logic [WIDTH-1:0] rd_pd;
  logic [AW-1:0]    ram_wa;
  logic             ram_we;
  logic [WIDTH-1:0] ram_di;
  logic [AW-1:0]    ram_ra;
  logic             ram_re;
  logic [WIDTH-1:0] ram_dout;
  logic [AW:0]      count;
  logic             idle;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state: the queue holds every stored entry, head first.
  logic [WIDTH-1:0] modelQ[$];
  int pushedTotal  = 0;
  int poppedTotal  = 0;
  int acceptedEver = 0;
  bit modelValid   = 1'b0;

  // Clock generation.
  always #5 clk = ~clk;

  // Behavioural two-port RAM: write at the edge, read address latched at the
  // edge, read data combinational from the latched address.
  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic [AW-1:0]    raLatch = '0;

  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) raLatch <= ram_ra;
  end

  assign ram_dout = mem[raLatch];

  nv_ram_rws_32x512_fifo_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .wr_pvld  (wr_pvld),
    .wr_prdy  (wr_prdy),
    .wr_pd    (wr_pd),
    .rd_pvld  (rd_pvld),
    .rd_prdy  (rd_prdy),
    .rd_pd    (rd_pd),
    .ram_wa   (ram_wa),
    .ram_we   (ram_we),
    .ram_di   (ram_di),
    .ram_ra   (ram_ra),
    .ram_re   (ram_re),
    .ram_dout (ram_dout),
    .count    (count),
    .idle     (idle)
  );

  // Single comparison point: counts it and reports a failure.
  task automatic cmp(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] randData();
    logic [WIDTH-1:0] d;
    for (int i = 0; i < WIDTH / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Drive one cycle of inputs just after the active edge.
  task automatic applyStimulus(input logic r, input logic vld, input logic [WIDTH-1:0] d, input logic prdy);
    @(posedge clk);
    #1;
    rst     = r;
    wr_pvld = vld;
    wr_pd   = d;
    rd_prdy = prdy;
  endtask

  // Compare the DUT against the model mid-cycle, then advance the model by
  // whatever handshakes the model says happen at the coming edge.
  task automatic checkOutput();
    int  sz;
    int  notPresented;
    bit  expAcc;
    bit  expPop;
    bit  expFetch;
    sz           = modelQ.size();
    notPresented = (sz > 0) ? sz - 1 : 0;
    expAcc       = wr_pvld && (sz < DEPTH);
    expPop       = rd_prdy && (sz > 0);
    expFetch     = ((notPresented != 0) || expAcc) && ((sz == 0) || rd_prdy);

    cmp("ramWeInReset", ram_we, rst ? 1'b0 : WIDTH'(expAcc && modelValid ? 1 : ram_we));
    if (rst) begin
      cmp("ramReInReset", ram_re, '0);
      if (modelValid) begin
        cmp("countBeforeReset", count, sz);
        cmp("rdPvldBeforeReset", rd_pvld, sz != 0);
      end
      modelQ.delete();
      pushedTotal = 0;
      poppedTotal = 0;
      modelValid  = 1'b1;
      return;
    end
    if (!modelValid) return;

    cmp("wrPrdy", wr_prdy, sz != DEPTH);
    cmp("rdPvld", rd_pvld, sz != 0);
    cmp("count", count, sz);
    cmp("idle", idle, sz == 0);
    cmp("ramWe", ram_we, expAcc);
    cmp("ramRe", ram_re, expFetch);
    if (expAcc) begin
      cmp("ramWa", ram_wa, pushedTotal % DEPTH);
      cmp("ramDi", ram_di, wr_pd);
    end
    if (expFetch) cmp("ramRa", ram_ra, (poppedTotal + ((sz > 0) ? 1 : 0)) % DEPTH);
    if (sz > 0) cmp("rdPd", rd_pd, modelQ[0]);

    if (expPop) begin
      void'(modelQ.pop_front());
      poppedTotal++;
    end
    if (expAcc) begin
      modelQ.push_back(wr_pd);
      pushedTotal++;
      acceptedEver++;
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) checkOutput();

  // Pop until the model is empty, with a cycle bound.
  task automatic drain();
    int n = 0;
    while (modelQ.size() != 0 && n < 4 * DEPTH) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      n++;
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    cmp("drainIdle", idle, 1'b1);
  endtask

  // Stimulus sequence.
  initial begin
    int target;
    int cycles;
    int stall;
    logic p;

    // Reset for a few cycles, then check the reset state.
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    cmp("resetWrPrdy", wr_prdy, 1'b1);
    cmp("resetIdle", idle, 1'b1);

    // Single push with bypass fetch.
    applyStimulus(1'b0, 1'b1, WIDTH'(512'hA5), 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    cmp("bypassData", rd_pd, WIDTH'(512'hA5));
    applyStimulus(1'b0, 1'b0, '0, 1'b1);

    // Fill to full with data 0..31, then try a 33rd push.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, WIDTH'(i), 1'b0);
    applyStimulus(1'b0, 1'b1, WIDTH'(99), 1'b0);
    cmp("fullCount", count, DEPTH);

    // Pop and push together while full, then push into the freed slot.
    applyStimulus(1'b0, 1'b1, WIDTH'(100), 1'b1);
    applyStimulus(1'b0, 1'b1, WIDTH'(101), 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    drain();

    // Continuous streaming.
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b1, randData(), 1'b1);
    drain();

    // Random traffic with read stalls of 1-5 cycles.
    target = acceptedEver + 1000;
    cycles = 0;
    stall  = 0;
    while (acceptedEver < target && cycles < 20000) begin
      if (stall > 0) begin
        p = 1'b0;
        stall--;
      end else begin
        p = 1'b1;
        if ($urandom_range(0, 3) == 0) stall = $urandom_range(1, 5);
      end
      applyStimulus(1'b0, $urandom_range(0, 3) != 0, randData(), p);
      cycles++;
    end
    cmp("randomBudget", acceptedEver >= target, 1'b1);
    drain();

    // Reset in the middle of traffic with 7 entries held.
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, randData(), 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    cmp("postResetCount", count, '0);
    cmp("postResetRdPvld", rd_pvld, 1'b0);
    applyStimulus(1'b0, 1'b1, WIDTH'(1), 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    cmp("postResetData", rd_pd, WIDTH'(1));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule : tb_nv_ram_rws_32x512_fifo_ctrl

// File: doc/nv_ram_rws_32x512_fifo_ctrl.md
Name: nv_ram_rws_32x512_fifo_ctrl

Overview:
- Valid/ready FIFO controller that owns a 32-entry x 512-bit two-port RAM (separate read/write address, registered read address, combinational read data).
- Converts a push interface into RAM writes and RAM reads into a pop interface with a one-cycle RAM read latency.
- Sits directly upstream (write side) and downstream (read side) of the RAM macro in datapath buffering stages.
- Instantiated alongside the RAM and wired port-to-port.

Parameters:
- DEPTH, 32, number of entries; must be a power of 2; matches RAM depth.
- AW, 5, address width = log2(DEPTH).
- WIDTH, 512, payload width; matches RAM data width.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- wr_pvld  input  1  push valid.
- wr_prdy  output  1  push ready.
- wr_pd  input  WIDTH  push payload.
- rd_pvld  output  1  pop valid.
- rd_prdy  input  1  pop ready.
- rd_pd  output  WIDTH  pop payload; equals ram_dout.
- ram_wa  output  AW  RAM write address.
- ram_we  output  1  RAM write enable.
- ram_di  output  WIDTH  RAM write data; equals wr_pd.
- ram_ra  output  AW  RAM read address.
- ram_re  output  1  RAM read enable (latches ram_ra at the clock edge).
- ram_dout  input  WIDTH  RAM read data; M[latched ra], combinational from RAM.
- count  output  AW+1  occupancy 0..DEPTH, including the entry presented on rd_*.
- idle  output  1  count==0.

Behaviour:
- Interface: clk is the single clock. rst is synchronous and active-high.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, rd_pvld=0. Hence wr_prdy=1 and idle=1. ram_we and ram_re are 0 while rst=1.
- push = wr_pvld & wr_prdy.
- pop = rd_pvld & rd_prdy.
- wr_prdy = (count != DEPTH). It is combinational from the count register only and does not depend on rd_prdy in the same cycle.
- ram_we = push. ram_wa = wr_ptr. wr_ptr increments mod DEPTH on push.
- unfetched = count - rd_pvld. This is the number of stored entries not yet read into the output.
- fetch = (unfetched != 0 | push) & (!rd_pvld | rd_prdy).
- ram_re = fetch. ram_ra = rd_ptr. rd_ptr increments mod DEPTH on fetch.
- rd_pvld next = fetch ? 1 : (pop ? 0 : rd_pvld).
- Bypass fetch: when empty and pushing, fetch in the same cycle with ram_ra == ram_wa.
  - The RAM write and the read-address latch take effect at the same edge, so ram_dout shows the new data next cycle.
  - Latency from accepted push to rd_pvld=1 is exactly 1 cycle.
- count next = count + push - pop. Simultaneous push and pop leave count unchanged.
- Full throughput: with continuous rd_prdy=1 and wr_pvld=1, one push and one pop per cycle.
- Stall: while rd_pvld=1 and rd_prdy=0, ram_re=0. The latched address and rd_pd are held. The held entry is still counted, so it cannot be overwritten until popped (wrap-around safe).
- Full (count==DEPTH): wr_prdy=0 and ram_we=0. A pop while full frees a slot, and wr_prdy returns to 1 the next cycle.
- Empty with no push: ram_re=0 and rd_pvld falls after the final pop.
- Pointer wrap: 31 -> 0 for both pointers, with no special casing.
- rst asserted mid-operation: all state returns to reset values at the next edge and contents are discarded. ram_we=0 and ram_re=0 during reset, so RAM contents are untouched.
- Arithmetic: count is AW+1 bits; pointers are AW bits with natural wrap. No X propagation from ram_dout into any control signal.
- Power:
  - ram_re is asserted only on fetch.
  - pwrbus_ram_pd is tied at the RAM by the parent; the RAM's pwrbus_ram_pd is not a port of this block.

Decomposition:
- Shared package holds DEPTH, AW and WIDTH defaults, plus a localparam for the count width AW+1.
- One natural sub-module: nv_fifo_ptr_cnt, containing the wr_ptr, rd_ptr and count registers with push/fetch/pop inputs.
- The RAM itself is instantiated by the parent, not inside this block.

Test Plan:
- Reset then one push of 512'hA5 at cycle 0 with rd_prdy=1 -> ram_we=1, ram_wa=0, ram_re=1, ram_ra=0 at cycle 0; rd_pvld=1 and rd_pd=512'hA5 at cycle 1; count 1 then 0 after the pop.
- 32 pushes of data i (0..31) with rd_prdy=0 -> wr_prdy=0 after the 32nd push, count=32, rd_pd=0 held. A 33rd wr_pvld is not accepted and ram_we=0.
- From full, pop one and push one in the same cycle: the push must not be accepted that cycle (wr_prdy=0) -> count=31. Next cycle wr_prdy=1; push lands at wa=0 after wrap; the output sequence continues 1, 2, ...
- Continuous streaming of 100 items with rd_prdy=1 -> one item out per cycle after 1 cycle of latency. Data is in order; count stays at 1; pointers wrap 31 -> 0 three times.
- Random rd_prdy stalls of 1-5 cycles -> rd_pd stable while stalled, ram_re=0 while stalled, no data loss or duplication across 1000 items versus a reference queue.
- Assert rst with count=7 and rd_pvld=1 -> the next cycle has count=0, rd_pvld=0, wr_prdy=1, idle=1. A following push of 512'h1 appears on rd_pd after 1 cycle.
